// File: rtl/fnd_display_arbiter_if.sv
// Bus between the BCD sources / mode button and the FND arbiter.
// The master side drives source digits and requests; the slave side (arbiter) returns the display.
interface fnd_display_arbiter_if;
  logic        btn_mode;
  logic [15:0] src0_value;
  logic [15:0] src1_value;
  logic [15:0] src2_value;
  logic [3:0]  src0_blink;
  logic [3:0]  src1_blink;
  logic [3:0]  src2_blink;
  logic        alert_req;
  logic [15:0] fnd_value;
  logic [3:0]  fnd_blank;
  logic [1:0]  sel;
  logic        alert_ack;

  modport master (
    output btn_mode, src0_value, src1_value, src2_value,
    output src0_blink, src1_blink, src2_blink, alert_req,
    input  fnd_value, fnd_blank, sel, alert_ack
  );

  modport slave (
    input  btn_mode, src0_value, src1_value, src2_value,
    input  src0_blink, src1_blink, src2_blink, alert_req,
    output fnd_value, fnd_blank, sel, alert_ack
  );
endinterface

// File: rtl/fnd_display_arbiter.sv
// Shares one 4-digit FND between watch, stopwatch and timer; shows a short banner
// on source change and lets a timer alert pre-empt the display until acked or withdrawn.
module fnd_display_arbiter #(
  parameter int TICKS_PER_MS = 100000,
  parameter int BANNER_MS    = 1000,
  parameter int BLINK_MS     = 500
) (
  input  logic                 clk,
  input  logic                 reset_p,
  fnd_display_arbiter_if.slave bus
);

  localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int BAN_W = (BANNER_MS > 1)    ? $clog2(BANNER_MS)    : 1;
  localparam int BLK_W = (BLINK_MS > 1)     ? $clog2(BLINK_MS)     : 1;

  typedef enum logic [1:0] {S_SHOW, S_BANNER, S_ALERT} state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_sel, w_sel_nxt;
  logic [PRE_W-1:0]   r_pre;
  logic [BAN_W-1:0]   r_ban;
  logic [BLK_W-1:0]   r_blink;
  logic               r_phase;
  logic               w_ms_tick, w_ban_last, w_ban_load, w_ack_nxt;
  logic [15:0]        w_src_value, w_value, r_value;
  logic [3:0]         w_src_blink, w_blank, r_blank;
  logic               r_ack;

  assign w_ms_tick  = (r_pre == PRE_W'(TICKS_PER_MS - 1));
  assign w_ban_last = (r_ban == BAN_W'(BANNER_MS - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_p) r_pre <= '0;
    else if (w_ms_tick) r_pre <= '0;
    else r_pre <= r_pre + 1'b1;
  end

  // Blink phase runs freely; mode changes never disturb it.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_blink <= '0;
      r_phase <= 1'b0;
    end else if (w_ms_tick) begin
      if (r_blink == BLK_W'(BLINK_MS - 1)) begin
        r_blink <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= r_blink + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) r_ban <= '0;
    else if (w_ban_load) r_ban <= '0;
    else if (r_state == S_BANNER && w_ms_tick) r_ban <= w_ban_last ? '0 : r_ban + 1'b1;
  end

  // NOTE: defaults first so every path assigns every signal; no latches.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ban_load  = 1'b0;
    w_ack_nxt   = 1'b0;
    if (r_state != S_ALERT && bus.alert_req) begin
      w_state_nxt = S_ALERT;
    end else if (r_state == S_ALERT) begin
      if (bus.btn_mode) begin
        w_state_nxt = S_SHOW;
        w_ack_nxt   = 1'b1;
      end else if (!bus.alert_req) begin
        w_state_nxt = S_SHOW;
      end
    end else if (bus.btn_mode) begin
      w_state_nxt = S_BANNER;
      w_sel_nxt   = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
      w_ban_load  = 1'b1;
    end else if (r_state == S_BANNER && w_ms_tick && w_ban_last) begin
      w_state_nxt = S_SHOW;
    end
  end

  always_comb begin
    unique case (r_sel)
      2'd0:    begin w_src_value = bus.src0_value; w_src_blink = bus.src0_blink; end
      2'd1:    begin w_src_value = bus.src1_value; w_src_blink = bus.src1_blink; end
      default: begin w_src_value = bus.src2_value; w_src_blink = bus.src2_blink; end
    endcase
  end

  always_comb begin
    w_value = w_src_value;
    w_blank = w_src_blink & {4{r_phase}};
    case (r_state)
      S_BANNER: begin
        w_value = {4'hD, 8'h00, 2'b00, r_sel};
        w_blank = 4'b0110;
      end
      S_ALERT: begin
        w_value = bus.src2_value;
        w_blank = {4{r_phase}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_state <= S_SHOW;
      r_sel   <= 2'd0;
      r_value <= '0;
      r_blank <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_value <= w_value;
      r_blank <= w_blank;
      r_ack   <= w_ack_nxt;
    end
  end

  assign bus.fnd_value = r_value;
  assign bus.fnd_blank = r_blank;
  assign bus.sel       = r_sel;
  assign bus.alert_ack = r_ack;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed bench for fnd_display_arbiter with a fast tick (2 clk/ms, 5 ms banner, 3 ms blink).
module tb_fnd_display_arbiter;

  logic clk = 1'b0;
  logic reset_p;
  always #5 clk = ~clk;

  fnd_display_arbiter_if u_if ();

  fnd_display_arbiter #(
    .TICKS_PER_MS(2),
    .BANNER_MS   (5),
    .BLINK_MS    (3)
  ) u_dut (
    .clk    (clk),
    .reset_p(reset_p),
    .bus    (u_if.slave)
  );

  localparam logic [15:0] V0 = 16'h1234;
  localparam logic [15:0] V1 = 16'h5678;
  localparam logic [15:0] V2 = 16'h0999;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] exp_sel;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] src_of(input logic [1:0] s);
    case (s)
      2'd0:    return V0;
      2'd1:    return V1;
      default: return V2;
    endcase
  endfunction

  task automatic press();
    u_if.btn_mode = 1'b1;
    step();
    u_if.btn_mode = 1'b0;
    exp_sel = (exp_sel == 2'd2) ? 2'd0 : exp_sel + 2'd1;
  endtask

  // Banner is visible from P+1 through P+9 for either tick phase; SHOW by P+11.
  task automatic press_and_check();
    press();
    check("sel_step", u_if.sel, exp_sel);
    step();
    check("banner_first", u_if.fnd_value, {12'hD00, 2'b00, exp_sel});
    check("banner_blank", u_if.fnd_blank, 4'b0110);
    step(8);
    check("banner_last", u_if.fnd_value, {12'hD00, 2'b00, exp_sel});
    step(2);
    check("show_value", u_if.fnd_value, src_of(exp_sel));
    check("show_blank", u_if.fnd_blank, 4'b0000);
  endtask

  initial begin
    logic [3:0] prev, v;
    logic       found, seen_on, seen_off, ack_seen;

    u_if.btn_mode   = 1'b0;
    u_if.alert_req  = 1'b0;
    u_if.src0_value = V0;
    u_if.src1_value = V1;
    u_if.src2_value = V2;
    u_if.src0_blink = 4'b0000;
    u_if.src1_blink = 4'b0000;
    u_if.src2_blink = 4'b0000;
    reset_p = 1'b1;
    exp_sel = 2'd0;

    // 1. reset held three cycles
    step();
    check("rst_value_c1", u_if.fnd_value, 16'h0000);
    step();
    check("rst_value_c2", u_if.fnd_value, 16'h0000);
    step();
    check("rst_value_c3", u_if.fnd_value, 16'h0000);
    check("rst_ack", u_if.alert_ack, 1'b0);
    reset_p = 1'b0;
    step();
    check("post_rst_value", u_if.fnd_value, V0);
    check("post_rst_blank", u_if.fnd_blank, 4'b0000);
    check("post_rst_sel", u_if.sel, 2'd0);

    // 2. three presses cycle 1, 2, 0
    repeat (3) begin
      press_and_check();
      step(9);
    end
    check("sel_wrapped", u_if.sel, 2'd0);

    // 3. press during banner restarts it; back-to-back presses advance twice
    press();
    step(5);
    press();
    check("restart_sel", u_if.sel, exp_sel);
    step();
    check("restart_banner", u_if.fnd_value, {12'hD00, 2'b00, exp_sel});
    step(4);
    check("restart_held", u_if.fnd_value, {12'hD00, 2'b00, exp_sel});
    step(4);
    check("restart_last", u_if.fnd_value, {12'hD00, 2'b00, exp_sel});
    step(2);
    check("restart_show", u_if.fnd_value, src_of(exp_sel));
    u_if.btn_mode = 1'b1;
    step(2);
    u_if.btn_mode = 1'b0;
    exp_sel = (exp_sel == 2'd2) ? 2'd0 : exp_sel + 2'd1;
    exp_sel = (exp_sel == 2'd2) ? 2'd0 : exp_sel + 2'd1;
    check("double_press_sel", u_if.sel, exp_sel);
    step(12);
    check("double_press_show", u_if.fnd_value, src_of(exp_sel));

    // 4. per-digit blink on source 1
    u_if.src1_blink = 4'b0011;
    step(2);
    prev  = u_if.fnd_blank;
    found = 1'b0;
    for (int i = 0; i < 14 && !found; i++) begin
      step();
      if (u_if.fnd_blank !== prev) found = 1'b1;
    end
    check("blink_toggle_seen", found, 1'b1);
    v = u_if.fnd_blank;
    check("blink_mask", v & 4'b1100, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("blink_hold", u_if.fnd_blank, v);
    end
    step();
    check("blink_flip", u_if.fnd_blank, v ^ 4'b0011);
    press_and_check();
    press_and_check();
    check("sel_back_0", u_if.sel, 2'd0);

    // 5. alert coincident with a press, then ack and level re-entry
    u_if.alert_req = 1'b1;
    u_if.btn_mode  = 1'b1;
    step();
    u_if.btn_mode = 1'b0;
    check("alert_sel_kept", u_if.sel, 2'd0);
    step();
    check("alert_value", u_if.fnd_value, V2);
    seen_on  = 1'b0;
    seen_off = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (u_if.fnd_blank === 4'b1111) seen_on = 1'b1;
      if (u_if.fnd_blank === 4'b0000) seen_off = 1'b1;
      if (u_if.alert_ack !== 1'b0) ack_seen = 1'b1;
    end
    check("alert_blink_on", seen_on, 1'b1);
    check("alert_blink_off", seen_off, 1'b1);
    check("alert_no_early_ack", ack_seen, 1'b0);
    u_if.btn_mode = 1'b1;
    step();
    u_if.btn_mode = 1'b0;
    check("ack_pulse", u_if.alert_ack, 1'b1);
    check("ack_sel_kept", u_if.sel, 2'd0);
    step();
    check("ack_single", u_if.alert_ack, 1'b0);
    check("ack_show_src0", u_if.fnd_value, V0);
    step();
    check("alert_reentry", u_if.fnd_value, V2);

    // 6. withdrawn alert returns to SHOW without an ack; reset mid-alert
    u_if.alert_req = 1'b0;
    step();
    check("withdraw_no_ack", u_if.alert_ack, 1'b0);
    step();
    check("withdraw_show", u_if.fnd_value, V0);
    check("withdraw_no_ack2", u_if.alert_ack, 1'b0);
    press();
    step(2);
    u_if.alert_req = 1'b1;
    step(2);
    check("alert_from_banner", u_if.fnd_value, V2);
    check("alert_sel1", u_if.sel, 2'd1);
    reset_p = 1'b1;
    step();
    check("rst_alert_value", u_if.fnd_value, 16'h0000);
    check("rst_alert_blank", u_if.fnd_blank, 4'b0000);
    check("rst_alert_sel", u_if.sel, 2'd0);
    check("rst_alert_ack", u_if.alert_ack, 1'b0);
    u_if.alert_req = 1'b0;
    reset_p = 1'b0;
    exp_sel = 2'd0;
    step();
    check("rst_alert_show", u_if.fnd_value, V0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
